// File: rtl/vga_cmd_fifo.sv
// vga_cmd_fifo: first-word-fall-through command queue with fill level and sticky overflow for the vga command port
module vga_cmd_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic empty, full, push, pop;
    always_comb begin
        empty = wr_ptr == rd_ptr;
        full = wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0] && wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2];
        push = s_axis_tvalid_i && !full;
        pop = m_axis_tready_i && !empty;
        s_axis_tready_o = !full;
        m_axis_tvalid_o = !empty;
        m_axis_tdata_o = mem[rd_ptr[DEPTH_LOG2-1:0]];
        level_o = wr_ptr - rd_ptr;
    end
    always_ff @(posedge clk) begin
        if (!reset_i || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
            if (s_axis_tvalid_i && full) overflow_o <= 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (reset_i && !clear_i && push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= s_axis_tdata_i;
endmodule
